// File: rtl/slip_input_capture_buffer.sv
// slip_input_capture_buffer
// Brings WIDTH asynchronous pin inputs into the MasterClock domain. Each line is
// synchronised, the current level is tracked, and a snapshot of the whole word is
// queued in a small show-ahead FIFO whenever any bit changes. The CPU/DSP I/O
// decode drains the FIFO, so short edges are not lost between polls.
//
// Optional feature: define INPUT_CAPTURE_GLITCH_FILTER_EN to add a per-bit
// two-sample filter after the synchroniser (one extra cycle of latency; pulses of
// a single MasterClock cycle never reach level or the FIFO).
module slip_input_capture_buffer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     MasterClock,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         pin_in,
  input  logic                     rd,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         level,
  output logic                     evt_valid,
  output logic [WIDTH-1:0]         evt_data,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev_q;
  logic             change;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, push, pop, drop;

  // Synchroniser chain: stage 0 samples the raw pins, last stage is usable.
  always_ff @(posedge MasterClock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef INPUT_CAPTURE_GLITCH_FILTER_EN
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] diff;

  // One-cycle-old copy of the synchroniser output, used to confirm stability.
  always_ff @(posedge MasterClock or negedge resetn) begin
    if (!resetn) filt_q <= '0;
    else         filt_q <= sync_out;
  end

  // A bit is accepted only when it matched on two consecutive cycles; otherwise
  // it keeps the previously accepted value (prev_q is last cycle's level).
  assign diff  = sync_out ^ filt_q;
  assign level = (sync_out & ~diff) | (prev_q & diff);
`else
  assign level = sync_out;
`endif

  // Previous level, for change detection.
  always_ff @(posedge MasterClock or negedge resetn) begin
    if (!resetn) prev_q <= '0;
    else         prev_q <= level;
  end

  assign change = |(level ^ prev_q);

  // FIFO control: pop wins a slot for a simultaneous push when full; reads of an
  // empty FIFO are ignored; a push into a full FIFO without a pop is dropped.
  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(DEPTH));
    pop      = rd && !empty;
    push     = change && (!full || pop);
    drop     = change && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FIFO pointers, occupancy counter and sticky overflow flag.
  always_ff @(posedge MasterClock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Event storage; the tail slot takes the current level on every accepted push.
  always_ff @(posedge MasterClock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= level;
    end
  end

  assign evt_valid = !empty;
  assign evt_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_slip_input_capture_buffer.sv
module tb_slip_input_capture_buffer;

  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;
`ifdef INPUT_CAPTURE_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LVL = FILT ? S + 1 : S;
  localparam int LAT = LVL + 1;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] pin_in = '0;
  logic         rd = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [W-1:0] level;
  logic         evt_valid;
  logic [W-1:0] evt_data;
  logic [$clog2(D):0] evt_count;
  logic         overflow;

  always #5 clk = ~clk;

  slip_input_capture_buffer #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .MasterClock(clk),
    .resetn     (resetn),
    .pin_in     (pin_in),
    .rd         (rd),
    .clr_ovf    (clr_ovf),
    .level      (level),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_count  (evt_count),
    .overflow   (overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: pins sampled each edge; the synchronised value is the pin
  // sample S edges old; the filter accepts a bit after two equal synchronised
  // samples; the event queue follows the push/pop/drop rules directly.
  logic [W-1:0] hist[$];
  logic [W-1:0] q[$];
  logic [W-1:0] m_level, m_prev, m_sync_prev;
  bit           m_ovf;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist.delete();
      q.delete();
      m_level = '0;
      m_prev = '0;
      m_sync_prev = '0;
      m_ovf = 1'b0;
    end else begin
      bit chg, drop;
      logic [W-1:0] s_new;
      chg = (m_level != m_prev);
      drop = 1'b0;
      if (rd && q.size() > 0) void'(q.pop_front());
      if (chg) begin
        if (q.size() < D) q.push_back(m_level);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_prev = m_level;
      hist.push_back(pin_in);
      if (hist.size() > S) void'(hist.pop_front());
      s_new = (hist.size() == S) ? hist[0] : '0;
      if (FILT) begin
        for (int b = 0; b < W; b++)
          if (s_new[b] == m_sync_prev[b]) m_level[b] = s_new[b];
      end else begin
        m_level = s_new;
      end
      m_sync_prev = s_new;
    end
  end

  // Continuous compare of every output against the model.
  always @(negedge clk) begin
    chk("level", level, m_level);
    chk("evt_valid", evt_valid, q.size() > 0);
    chk("evt_data", evt_data, (q.size() > 0) ? q[0] : '0);
    chk("evt_count", evt_count, q.size());
    chk("overflow", overflow, m_ovf);
  end

  task automatic drain();
    int n = 0;
    while (evt_valid && n < 2 * D + 4) begin
      rd = 1'b1;
      cyc(1);
      n++;
    end
    rd = 1'b0;
    chk("drain_empty", evt_valid, 0);
  endtask

  initial begin
    // Test 1: reset and idle
    cyc(3);
    chk("rst_level", level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_data", evt_data, 0);
    resetn = 1'b1;
    cyc(6);
    chk("idle_count", evt_count, 0);
    chk("idle_ovf", overflow, 0);

    // Test 2: single change A5
    pin_in = 8'hA5;
    cyc(LVL);
    chk("t2_level", level, 8'hA5);
    chk("t2_not_yet", evt_valid, 0);
    cyc(LAT - LVL);
    chk("t2_valid", evt_valid, 1);
    chk("t2_data", evt_data, 8'hA5);
    chk("t2_count", evt_count, 1);
    rd = 1'b1; cyc(1); rd = 1'b0;
    chk("t2_popped", evt_valid, 0);

    // Test 3: five changes, overflow, ordered pops
    for (int k = 1; k <= 5; k++) begin
      pin_in = W'(k);
      cyc(4);
    end
    chk("t3_count", evt_count, 4);
    chk("t3_ovf", overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("t3_pop", evt_data, k);
      rd = 1'b1; cyc(1); rd = 1'b0;
    end
    chk("t3_empty", evt_valid, 0);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    chk("t3_clr", overflow, 0);

    // Test 4: full FIFO, change coincident with a pop
    for (int k = 6; k <= 9; k++) begin
      pin_in = W'(k);
      cyc(4);
    end
    chk("t4_full", evt_count, 4);
    pin_in = 8'h0F;
    cyc(LVL);
    rd = 1'b1; cyc(1); rd = 1'b0;
    chk("t4_count", evt_count, 4);
    chk("t4_ovf", overflow, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_pop", evt_data, (k == 3) ? 8'h0F : 7 + k);
      rd = 1'b1; cyc(1); rd = 1'b0;
    end

    // Test 5: one-cycle pulse
    pin_in = 8'h00;
    cyc(6);
    drain();
    pin_in = 8'h80; cyc(1); pin_in = 8'h00;
    cyc(8);
    if (FILT) begin
      chk("t5f_count", evt_count, 0);
      chk("t5f_level", level, 0);
    end else begin
      chk("t5_count", evt_count, 2);
      chk("t5_first", evt_data, 8'h80);
      rd = 1'b1; cyc(1); rd = 1'b0;
      chk("t5_second", evt_data, 8'h00);
    end
    drain();

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0, 1: pin_in = W'($urandom);
        2:    pin_in = pin_in ^ (W'(1) << $urandom_range(0, W - 1));
        default: ;
      endcase
      rd = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    rd = 1'b0;
    clr_ovf = 1'b0;

    // Test 6: reset mid-stream
    pin_in = 8'h00;
    cyc(6);
    drain();
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    pin_in = 8'h11; cyc(4);
    pin_in = 8'h22; cyc(4);
    pin_in = 8'h33; cyc(4);
    chk("t6_count3", evt_count, 3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_level", level, 0);
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_data", evt_data, 0);
    chk("t6_rst_count", evt_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    pin_in = 8'h3C;
    @(negedge clk);
    resetn = 1'b1;
    cyc(8);
    chk("t6_count1", evt_count, 1);
    chk("t6_data", evt_data, 8'h3C);
    rd = 1'b1; cyc(1); rd = 1'b0;
    cyc(4);
    chk("t6_drained", evt_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
